// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// memresp_types
// Shared types and constants for the memory responder: FSM state encoding,
// request record latched at acceptance, latency limits and a helper that turns
// a latched request into per-lane write enables.
// -----------------------------------------------------------------------------
package memresp_types;

    // Largest supported request-to-response latency (counter must hold it).
    localparam int unsigned MAX_LATENCY = 32'd15;
    localparam int unsigned CNT_W       = 32'd4;
    // Widest possible word index for a 32-bit byte address.
    localparam int unsigned MAX_IDX_W   = 32'd30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } memresp_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } memresp_op_t;

    // Request captured at acceptance; err covers both range and illegal ops.
    typedef struct packed {
        memresp_op_t            op;
        logic [MAX_IDX_W-1:0]   index;
        logic [3:0]             be;
        logic [31:0]            wdata;
        logic                   err;
    } memresp_req_t;

    // Lane write enables for a request; nothing is written for reads,
    // errored requests, or when commit is low.
    function automatic logic [3:0] write_lanes(input memresp_req_t req,
                                               input logic         commit);
        logic [3:0] lanes;
        if (commit && (req.op == OP_WRITE) && !req.err) begin
            lanes = req.be;
        end else begin
            lanes = 4'b0000;
        end
        return lanes;
    endfunction

endpackage : memresp_types

// File: rtl/mem_responder_mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// 2**ADDR_BITS x 32-bit storage with four byte-lane write enables and a
// combinational read port. Contents are deliberately not reset.
//   clk    : rising-edge clock for writes
//   we     : per-lane write enable, bit i covers bits 8i+7:8i
//   waddr  : write word index
//   wdata  : write data
//   raddr  : read word index
//   rdata  : combinational read data
// -----------------------------------------------------------------------------
module mem_array #(
    parameter int unsigned ADDR_BITS = 32'd10
) (
    input  logic                 clk,
    input  logic [3:0]           we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [31:0]          wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [31:0]          rdata
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_BITS;

    logic [31:0] mem_q [DEPTH];

    // Byte-lane write port; untouched lanes keep their contents.
    always_ff @(posedge clk) begin
        for (int unsigned i = 32'd0; i < 32'd4; i++) begin
            if (we[i]) begin
                mem_q[waddr][32'd8*i +: 8] <= wdata[32'd8*i +: 8];
            end
        end
    end

    assign rdata = mem_q[raddr];

endmodule : mem_array

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Fixed-latency memory responder for the RV32I multicycle core. Accepts one
// request at a time, waits LATENCY cycles from the request's first cycle and
// returns a one-cycle mem_resp pulse with read data or commits a byte-lane
// write at the end of the response cycle.
//   clk             : rising-edge clock
//   rst             : asynchronous active-low reset
//   mem_read        : read strobe, held until mem_resp
//   mem_write       : write strobe, held until mem_resp
//   mem_address     : byte address, bits [1:0] ignored
//   mem_byte_enable : write lane enables
//   mem_wdata       : write data
//   mem_rdata       : read data, non-zero only in the response cycle
//   mem_resp        : one-cycle completion pulse
//   mem_err         : qualifies mem_resp (out of range or read+write)
//   busy            : high from acceptance through the response cycle
// -----------------------------------------------------------------------------
module mem_responder
    import memresp_types::*;
#(
    parameter int unsigned ADDR_BITS = 32'd10,
    parameter int unsigned LATENCY   = 32'd3,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        mem_err,
    output logic        busy
);

    // Counter start value: the acceptance cycle already counts as one.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 32'd1);

    memresp_state_t         state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    memresp_req_t           req_q, req_d;
    logic                   mem_resp_q, mem_resp_d;
    logic                   mem_err_q, mem_err_d;
    logic [31:0]            mem_rdata_q, mem_rdata_d;
    logic                   busy_q, busy_d;

    logic [31:0]            offset_s;
    logic [MAX_IDX_W-1:0]   word_s;
    logic                   range_err_s;
    memresp_req_t           new_req_s;
    logic [ADDR_BITS-1:0]   rd_idx_s;
    logic                   rd_valid_s;
    logic                   cur_err_s;
    logic [31:0]            arr_rdata_s;
    logic [3:0]             we_s;
    logic                   unused_ok_s;

    // Decode the incoming request: word index, range check and illegal op.
    always_comb begin
        offset_s    = mem_address - BASE_ADDR;
        word_s      = offset_s[31:2];
        range_err_s = (mem_address < BASE_ADDR) || (|(word_s >> ADDR_BITS));
        new_req_s       = memresp_req_t'('0);
        if (mem_write) begin
            new_req_s.op = OP_WRITE;
        end else begin
            new_req_s.op = OP_READ;
        end
        new_req_s.index = word_s;
        new_req_s.be    = mem_byte_enable;
        new_req_s.wdata = mem_wdata;
        new_req_s.err   = range_err_s || (mem_read && mem_write);
    end

    // Select which request feeds the response: with LATENCY=1 the response
    // is formed on the acceptance edge, before the request has been latched.
    always_comb begin
        rd_idx_s   = '0;
        rd_valid_s = 1'b0;
        cur_err_s  = 1'b0;
        if (state_q == IDLE) begin
            rd_idx_s   = new_req_s.index[ADDR_BITS-1:0];
            rd_valid_s = (new_req_s.op == OP_READ) && !new_req_s.err;
            cur_err_s  = new_req_s.err;
        end else begin
            rd_idx_s   = req_q.index[ADDR_BITS-1:0];
            rd_valid_s = (req_q.op == OP_READ) && !req_q.err;
            cur_err_s  = req_q.err;
        end
    end

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    req_d = new_req_s;
                    if (LATENCY == 32'd1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        mem_resp_d = (state_d == RESP);
        busy_d     = (state_d != IDLE);
        mem_err_d  = (state_d == RESP) && cur_err_s;
        if ((state_d == RESP) && rd_valid_s) begin
            mem_rdata_d = arr_rdata_s;
        end else begin
            mem_rdata_d = 32'h0000_0000;
        end
    end

    // State, latched request and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= memresp_req_t'('0);
            mem_resp_q  <= 1'b0;
            mem_err_q   <= 1'b0;
            mem_rdata_q <= 32'h0000_0000;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            mem_resp_q  <= mem_resp_d;
            mem_err_q   <= mem_err_d;
            mem_rdata_q <= mem_rdata_d;
            busy_q      <= busy_d;
        end
    end

    // A write lands on the edge that ends the response cycle; a reset in
    // WAIT leaves state_q in IDLE, so the pending write never commits.
    assign we_s = write_lanes(req_q, (state_q == RESP));

    mem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_mem_array (
        .clk   (clk),
        .we    (we_s),
        .waddr (req_q.index[ADDR_BITS-1:0]),
        .wdata (req_q.wdata),
        .raddr (rd_idx_s),
        .rdata (arr_rdata_s)
    );

    // Byte-offset bits and index bits above the array depth carry no data.
    assign unused_ok_s = &{1'b0, offset_s[1:0], req_q.index[MAX_IDX_W-1:ADDR_BITS]};

    assign mem_rdata = mem_rdata_q;
    assign mem_resp  = mem_resp_q;
    assign mem_err   = mem_err_q;
    assign busy      = busy_q;

endmodule : mem_responder
